// File: rtl/alu_serial_pkg.sv
// Shared definitions for the serial ALU: operation encodings, FSM states
// and small decode helpers used by the slice and the control logic.
package alu_serial_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    // ADD and SLT both go through the adder and report carry/overflow.
    function automatic logic is_arith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice: operand inversion, and/or/ripple sum,
// operation mux, plus the carry out of and the carry into the slice MSB.
module alu_slice
    import alu_serial_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ainvert,
    input  logic             binvert,
    input  logic [1:0]       operation,
    input  logic             carry_in,
    output logic [SLICE-1:0] result,
    output logic             carry_out,
    output logic             carry_msb
);

    logic [SLICE-1:0] aa;
    logic [SLICE-1:0] bb;
    logic [SLICE-1:0] sum;
    logic [SLICE:0]   c;

    always_comb begin
        aa = ainvert ? ~a : a;
        bb = binvert ? ~b : b;
        c  = '0;
        sum = '0;
        c[0] = carry_in;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = aa[i] ^ bb[i] ^ c[i];
            c[i + 1] = (aa[i] & bb[i]) | (aa[i] & c[i]) | (bb[i] & c[i]);
        end
    end

    // SLT passes the raw sum through; its MSB becomes the Set bit in FIX.
    always_comb begin
        result = '0;
        case (operation)
            OP_AND:  result = aa & bb;
            OP_OR:   result = aa | bb;
            default: result = sum;
        endcase
    end

    assign carry_out = c[SLICE];
    assign carry_msb = c[SLICE-1];

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle WIDTH-bit ALU processing SLICE bits per clock through one shared
// slice. Optional Zero flag is built when ALU_SERIAL_ZERO_EN is defined.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ainvert,
    input  logic             Binvert,
    input  logic [1:0]       Operation,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry_out,
    output logic             Overflow,
`ifdef ALU_SERIAL_ZERO_EN
    output logic             Zero,
`endif
    output state_t           state
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 2) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic [WIDTH-SLICE-1:0] res_sh;
    logic                   ainv_q;
    logic                   binv_q;
    logic [1:0]             op_q;
    logic                   carry_q;
    logic [CW-1:0]          cnt;
    logic                   set_q;
    logic                   ovf_q;
    logic                   cout_q;
`ifdef ALU_SERIAL_ZERO_EN
    logic [SLICE-1:0]       acc;
`endif

    logic [SLICE-1:0] slice_res;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             slice_ovf;

    alu_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a         (a_sh[SLICE-1:0]),
        .b         (b_sh[SLICE-1:0]),
        .ainvert   (ainv_q),
        .binvert   (binv_q),
        .operation (op_q),
        .carry_in  (carry_q),
        .result    (slice_res),
        .carry_out (slice_cout),
        .carry_msb (slice_cmsb)
    );

    assign slice_ovf = slice_cmsb ^ slice_cout;

    // Result and flags are written only on the completing edge, so the
    // partial result lives in res_sh and never appears on Result.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Result    <= '0;
            Carry_out <= 1'b0;
            Overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            ainv_q    <= 1'b0;
            binv_q    <= 1'b0;
            op_q      <= OP_AND;
            carry_q   <= 1'b0;
            cnt       <= '0;
            set_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cout_q    <= 1'b0;
`ifdef ALU_SERIAL_ZERO_EN
            acc       <= '0;
            Zero      <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        ainv_q  <= Ainvert;
                        binv_q  <= Binvert;
                        op_q    <= Operation;
                        carry_q <= Binvert;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        state   <= RUN;
`ifdef ALU_SERIAL_ZERO_EN
                        acc     <= '0;
`endif
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> SLICE;
                    b_sh    <= b_sh >> SLICE;
                    res_sh  <= (WIDTH-SLICE)'({slice_res, res_sh} >> SLICE);
                    carry_q <= slice_cout;
                    cnt     <= cnt + 1'b1;
`ifdef ALU_SERIAL_ZERO_EN
                    acc     <= acc | slice_res;
`endif
                    if (cnt == LAST) begin
                        if (op_q == OP_SLT) begin
                            set_q  <= slice_res[SLICE-1];
                            ovf_q  <= slice_ovf;
                            cout_q <= slice_cout;
                            state  <= FIX;
                        end else begin
                            Result    <= {slice_res, res_sh};
                            Carry_out <= is_arith(op_q) & slice_cout;
                            Overflow  <= is_arith(op_q) & slice_ovf;
                            Done      <= 1'b1;
                            Busy      <= 1'b0;
                            state     <= IDLE;
`ifdef ALU_SERIAL_ZERO_EN
                            Zero      <= ~|(acc | slice_res);
`endif
                        end
                    end
                end
                FIX: begin
                    Result    <= {{(WIDTH-1){1'b0}}, set_q ^ ovf_q};
                    Carry_out <= cout_q;
                    Overflow  <= ovf_q;
                    Done      <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= IDLE;
`ifdef ALU_SERIAL_ZERO_EN
                    Zero      <= ~(set_q ^ ovf_q);
`endif
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_alu_serial;
    import alu_serial_pkg::*;

    localparam int W      = 32;
    localparam int NSLICE = 8;

    logic         Clock;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ainvert;
    logic         Binvert;
    logic [1:0]   Operation;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Carry_out;
    logic         Overflow;
`ifdef ALU_SERIAL_ZERO_EN
    logic         Zero;
`endif
    state_t       st;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   expf_q[$];

    alu_serial #(
        .WIDTH(W),
        .SLICE(4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Ainvert   (Ainvert),
        .Binvert   (Binvert),
        .Operation (Operation),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .Carry_out (Carry_out),
        .Overflow  (Overflow),
`ifdef ALU_SERIAL_ZERO_EN
        .Zero      (Zero),
`endif
        .state     (st)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ai;
        logic         bi;
        logic [1:0]   op;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic straight from the operation rules.
    function automatic void model(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                  input logic ai, input logic bi, input logic [1:0] op,
                                  output logic [W-1:0] res, output logic co,
                                  output logic ov, output int lat);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   s;
        logic         ovf;
        a   = ai ? ~a_in : a_in;
        b   = bi ? ~b_in : b_in;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bi};
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        lat = NSLICE;
        co  = 1'b0;
        ov  = 1'b0;
        case (op)
            2'b00: res = a & b;
            2'b01: res = a | b;
            2'b10: begin res = s[W-1:0]; co = s[W]; ov = ovf; end
            default: begin
                res = {{(W-1){1'b0}}, s[W-1] ^ ovf};
                co  = s[W];
                ov  = ovf;
                lat = NSLICE + 1;
            end
        endcase
    endfunction

    // driver: called #1 after a rising edge; Start held for exactly one edge
    task automatic issue(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic ai, input logic bi, input logic [1:0] op);
        A = a_v; B = b_v; Ainvert = ai; Binvert = bi; Operation = op;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("busy_after_start", {31'b0, Busy}, 32'd1);
    endtask

    task automatic wait_done(input int c0, output int cyc, output bit ok);
        cyc = c0;
        ok  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge Clock); #1;
            cyc++;
            if (Done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic ai, input logic bi, input logic [1:0] op,
                          input logic [W-1:0] res, input logic co, input logic ov, input int lat);
        int           cyc;
        bit           ok;
        logic [W-1:0] er;
        logic [1:0]   ef;
        exp_q.push_back(res);
        expf_q.push_back({co, ov});
        issue(a_v, b_v, ai, bi, op);
        wait_done(0, cyc, ok);
        er = exp_q.pop_front();
        ef = expf_q.pop_front();
        if (ok) begin
            check({name, "_result"}, Result, er);
            check({name, "_cout"}, {31'b0, Carry_out}, {31'b0, ef[1]});
            check({name, "_ovf"}, {31'b0, Overflow}, {31'b0, ef[0]});
            check({name, "_latency"}, cyc, lat);
            check({name, "_busy_low"}, {31'b0, Busy}, 32'd0);
`ifdef ALU_SERIAL_ZERO_EN
            check({name, "_zero"}, {31'b0, Zero}, {31'b0, (er == '0)});
`endif
        end
    endtask

    initial begin
        logic [W-1:0] mr;
        logic         mc;
        logic         mv;
        int           ml;
        int           cyc;
        bit           ok;
        bit           seen;
        logic [W-1:0] pick[5];

        vecs[0] = '{"add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 2'b10, 32'h80000000, 1'b0, 1'b1, 8};
        vecs[1] = '{"sub_eq",  32'h00000005, 32'h00000005, 1'b0, 1'b1, 2'b10, 32'h00000000, 1'b1, 1'b0, 8};
        vecs[2] = '{"slt_neg", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 2'b11, 32'h00000001, 1'b1, 1'b0, 9};
        vecs[3] = '{"slt_pos", 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b11, 32'h00000000, 1'b0, 1'b0, 9};
        vecs[4] = '{"and",     32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0, 2'b00, 32'h00F000F0, 1'b0, 1'b0, 8};
        vecs[5] = '{"or",      32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0, 2'b01, 32'hFFF0FFF0, 1'b0, 1'b0, 8};
        vecs[6] = '{"nor",     32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 1'b1, 2'b00, 32'h000F000F, 1'b0, 1'b0, 8};

        Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        Ainvert = 1'b0; Binvert = 1'b0; Operation = 2'b00;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_flags", {30'b0, Carry_out, Overflow}, 32'd0);
        check("rst_state", 32'(st), 32'(IDLE));
        Reset = 1'b0;
        @(posedge Clock); #1;

        // directed table
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ai, vecs[i].bi, vecs[i].op,
                   vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].lat);

        // back-to-back: new Start issued in the Done cycle
        run_op("b2b_first", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 2'b10, 32'h7FFFFFFF, 1'b1, 1'b1, 8);
        check("b2b_done_at_start", {31'b0, Done}, 32'd1);
        run_op("b2b_second", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 2'b10, 32'h23456789, 1'b0, 1'b0, 8);

        // reset four cycles into RUN
        issue(32'h00000001, 32'h00000002, 1'b0, 1'b0, 2'b10);
        repeat (4) begin @(posedge Clock); #1; end
        Reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_result", Result, 32'd0);
        check("abort_done", {31'b0, Done}, 32'd0);
        check("abort_state", 32'(st), 32'(IDLE));
        @(posedge Clock); #1;
        Reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin @(posedge Clock); #1; if (Done) seen = 1'b1; end
        check("abort_no_done", {31'b0, seen}, 32'd0);

        // Start while busy must be ignored
        issue(32'h00000100, 32'h00000023, 1'b0, 1'b0, 2'b10);
        repeat (3) begin @(posedge Clock); #1; end
        A = 32'hDEADBEEF; B = 32'h0BADF00D; Operation = 2'b01; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_done(4, cyc, ok);
        if (ok) begin
            check("ign_result", Result, 32'h00000123);
            check("ign_latency", cyc, NSLICE);
        end
        seen = 1'b0;
        repeat (12) begin @(posedge Clock); #1; if (Done) seen = 1'b1; end
        check("ign_no_extra_done", {31'b0, seen}, 32'd0);

        // randomized operations against the model
        pick[0] = 32'h00000000; pick[1] = 32'hFFFFFFFF; pick[2] = 32'h80000000;
        pick[3] = 32'h7FFFFFFF; pick[4] = 32'h00000001;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rai;
            logic         rbi;
            logic [1:0]   rop;
            ra  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            rai = 1'($urandom_range(0, 1));
            rbi = 1'($urandom_range(0, 1));
            rop = 2'($urandom_range(0, 3));
            model(ra, rb, rai, rbi, rop, mr, mc, mv, ml);
            run_op("rand", ra, rb, rai, rbi, rop, mr, mc, mv, ml);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
